apb_requester: RTL
==================

APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255, the number of consecutive ACCESS cycles with PREADY=0 that sets timeout_err (legal range 1..255).
REQ-002 SHALL have port PCLK  input  1  sole clock; all logic on the rising edge.
REQ-003 SHALL have port PRESETn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports cmd_valid  input  1, cmd_ready  output  1, cmd_addr  input  1, cmd_write  input  1, cmd_wdata  input  32, cmd_strb  input  4: the command channel, valid/ready handshake.
REQ-005 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_rdata  output  32, rsp_slverr  output  1: the response channel, valid/ready handshake.
REQ-006 SHALL have APB outputs PADDR 1, PSEL 1, PENABLE 1, PWRITE 1, PWDATA 32, PSTRB 4, and APB inputs PREADY 1, PRDATA 32, PSLVERR 1.
REQ-007 SHALL have status outputs busy  output  1 (state is not IDLE) and timeout_err  output  1 (sticky watchdog flag).

Function
REQ-008 SHALL hold accepted commands in a one-entry buffer; cmd_ready = buffer empty; a command is accepted on an edge where cmd_valid && cmd_ready.
REQ-009 SHALL implement states IDLE, SETUP and ACCESS.
REQ-010 In IDLE, SHALL move to SETUP when the buffer is full and the response slot is free (!rsp_valid || rsp_ready on that edge). On that edge it SHALL load PADDR, PWRITE, PWDATA and PSTRB from the buffer and empty the buffer.
REQ-011 In SETUP, SHALL drive PSEL=1, PENABLE=0 for exactly one cycle, then move to ACCESS unconditionally.
REQ-012 In ACCESS, SHALL drive PSEL=1, PENABLE=1. It SHALL remain in ACCESS while PREADY=0 and move to IDLE on the edge where PREADY=1.
REQ-013 On the completing edge, SHALL register rsp_rdata (PRDATA for reads, 0 for writes) and rsp_slverr (PSLVERR), and set rsp_valid=1.
REQ-014 rsp_valid SHALL stay asserted with stable data until an edge with rsp_ready=1.
REQ-015 SHALL keep PADDR, PWRITE, PWDATA and PSTRB stable from SETUP through the completing ACCESS cycle, and hold their last values in IDLE.
REQ-016 For reads, SHALL drive PSTRB=4'b0000 regardless of cmd_strb; for writes, PSTRB=cmd_strb.
REQ-017 Minimum latency: command accepted at edge 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid high in cycle 3 when PREADY=1 in cycle 2.
REQ-018 A new command MAY be accepted into the buffer while a transfer is in SETUP or ACCESS.
REQ-019 A buffered command SHALL NOT launch while an unconsumed response is held.
REQ-020 If acceptance and launch coincide, the buffer SHALL end full with the new command.
REQ-021 SHALL count consecutive ACCESS cycles with PREADY=0 in an 8-bit saturating counter, cleared on entering ACCESS.
REQ-022 When that counter reaches MAX_WAIT, SHALL set timeout_err=1. The transfer SHALL NOT be aborted, and timeout_err SHALL clear only on reset.
REQ-023 SHALL never assert PENABLE without PSEL, and never enter ACCESS except from SETUP.

Reset
REQ-024 On PRESETn=0, SHALL asynchronously force state IDLE and outputs PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0, busy=0, timeout_err=0, cmd_ready=0.
REQ-025 Reset SHALL empty the buffer and discard any in-flight transfer and pending response, including reset asserted mid-ACCESS.
REQ-026 cmd_ready SHALL rise on the first edge after PRESETn deasserts.

Structure
REQ-027 The state enum, a command struct (addr, write, wdata, strb) and a response struct (rdata, slverr) SHALL live in package apb_pkg for sharing with the completer and benches.
REQ-028 The one-entry command buffer SHALL be a sub-module apb_cmd_buf with valid/ready in, struct out and a pop input; all other logic SHALL remain in apb_requester.

Verification
REQ-029 Write addr=1, wdata=32'hDEADBEEF, strb=4'b0101, PREADY tied 1 -> SETUP in cycle 1, ACCESS in cycle 2, PSTRB=0101, rsp_valid in cycle 3 with rsp_rdata=0, rsp_slverr=0.
REQ-030 Read addr=0, strb=4'b1111, PREADY low for 3 ACCESS cycles then high with PRDATA=32'h12345678, PSLVERR=1 -> PSTRB=0000, address and control stable over 4 ACCESS cycles, rsp_rdata=32'h12345678, rsp_slverr=1.
REQ-031 Two commands back-to-back with rsp_ready held 0 -> second command accepted during the first transfer, second SETUP not entered until the edge rsp_ready=1, first response unchanged meanwhile.
REQ-032 MAX_WAIT=4, PREADY held 0 for 10 cycles then 1 -> timeout_err set after 4 wait cycles, transfer completes normally, timeout_err stays 1 until reset.
REQ-033 PRESETn pulsed low during ACCESS with rsp slot and buffer full -> PSEL, PENABLE, rsp_valid and cmd_ready all 0 immediately; after release, IDLE with cmd_ready=1 and no spurious transfer.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: types shared by the APB requester, its completer and benches
//    apb_state_t : requester FSM states
//    apb_cmd_t   : buffered command (addr, write, wdata, strb)
//    apb_rsp_t   : completed response (rdata, slverr)
package apb_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
   typedef struct packed {
      logic        addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } apb_cmd_t;
   typedef struct packed {
      logic [31:0] rdata;
      logic        slverr;
   } apb_rsp_t;
endpackage

// File: rtl/apb_cmd_buf.sv
// apb_cmd_buf: one-entry command buffer with valid/ready fill and pop drain
//    clk, rst_n      : clock, async active-low reset
//    in_valid/ready  : fill handshake, in_cmd is the offered command
//    pop             : empties the buffer on this edge
//    full, out_cmd   : occupancy and held command
module apb_cmd_buf
   import apb_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     in_valid,
   input  apb_cmd_t in_cmd,
   input  logic     pop,
   output logic     in_ready,
   output logic     full,
   output apb_cmd_t out_cmd
);
   // alive holds in_ready low until the first edge after reset release
   logic alive;
   assign in_ready = alive && !full;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         alive   <= 1'b0;
         full    <= 1'b0;
         out_cmd <= '0;
      end else begin
         alive <= 1'b1;
         // accepting wins so a coincident fill and pop leaves the new command held
         if (in_valid && in_ready) begin
            full    <= 1'b1;
            out_cmd <= in_cmd;
         end else if (pop)
            full <= 1'b0;
      end
endmodule

// File: rtl/apb_requester.sv
// apb_requester: turns valid/ready commands into APB transfers and returns responses
//    PCLK, PRESETn                          : clock, async active-low reset
//    cmd_valid/ready, cmd_addr/write/wdata/strb : command channel
//    rsp_valid/ready, rsp_rdata/slverr      : response channel
//    PADDR..PSTRB out, PREADY/PRDATA/PSLVERR in : APB requester port
//    busy, timeout_err                      : FSM not idle, sticky wait watchdog
module apb_requester
   import apb_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 255
)
(
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_addr,
   input  logic        cmd_write,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_strb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_slverr,
   output logic        PADDR,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [31:0] PWDATA,
   output logic [3:0]  PSTRB,
   input  logic        PREADY,
   input  logic [31:0] PRDATA,
   input  logic        PSLVERR,
   output logic        busy,
   output logic        timeout_err
);
   localparam logic [7:0] MAX_W = 8'(MAX_WAIT);
   apb_state_t state;
   apb_cmd_t   new_cmd, buf_cmd;
   apb_rsp_t   rsp;
   logic       buf_full, launch;
   logic [7:0] wait_cnt, wait_nxt;
   assign new_cmd    = {cmd_addr, cmd_write, cmd_wdata, cmd_strb};
   assign launch     = state == IDLE && buf_full && (!rsp_valid || rsp_ready);
   assign wait_nxt   = wait_cnt == 8'hFF ? 8'hFF : wait_cnt + 8'd1;
   assign busy       = state != IDLE;
   assign rsp_rdata  = rsp.rdata;
   assign rsp_slverr = rsp.slverr;
   apb_cmd_buf u_buf (
      .clk      (PCLK),
      .rst_n    (PRESETn),
      .in_valid (cmd_valid),
      .in_cmd   (new_cmd),
      .pop      (launch),
      .in_ready (cmd_ready),
      .full     (buf_full),
      .out_cmd  (buf_cmd)
   );
   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
         state       <= IDLE;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PADDR       <= 1'b0;
         PWRITE      <= 1'b0;
         PWDATA      <= '0;
         PSTRB       <= '0;
         rsp_valid   <= 1'b0;
         rsp         <= '0;
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
         case (state)
            IDLE:
               if (launch) begin
                  state  <= SETUP;
                  PSEL   <= 1'b1;
                  PADDR  <= buf_cmd.addr;
                  PWRITE <= buf_cmd.write;
                  PWDATA <= buf_cmd.wdata;
                  PSTRB  <= buf_cmd.write ? buf_cmd.strb : 4'b0000;
               end
            SETUP: begin
               state    <= ACCESS;
               PENABLE  <= 1'b1;
               wait_cnt <= '0;
            end
            ACCESS:
               if (PREADY) begin
                  state      <= IDLE;
                  PSEL       <= 1'b0;
                  PENABLE    <= 1'b0;
                  rsp_valid  <= 1'b1;
                  rsp.rdata  <= PWRITE ? 32'h0 : PRDATA;
                  rsp.slverr <= PSLVERR;
               end else begin
                  // watchdog only flags; the transfer keeps waiting for PREADY
                  wait_cnt <= wait_nxt;
                  if (wait_nxt >= MAX_W) timeout_err <= 1'b1;
               end
            default: state <= IDLE;
         endcase
      end
endmodule
